// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates an instruction-fetch port and a data port onto one
// single-ported memory. The memory signals completion with mem_ready.
// A per-access wait counter aborts an access that stalls for TIMEOUT
// cycles. The abort is reported by err, which pulses together with the
// done pulse.
//
// Build option: define ARB_STARVE_GUARD_EN to enable the fetch
// anti-starvation counter. After STARVE_MAX consecutive data grants issued
// while a fetch is waiting, the next arbitration goes to the fetch.
// Without the macro, data always has strict priority over fetch.
//
// Timing of one access:
//   grant cycle (IDLE, *_gnt=1)
//   one or more ACC cycles (mem_en=1)
//   done cycle (IDLE, *_done=1)
// The done cycle can also be the grant cycle of the next access, because
// arbitration also runs on the edge that completes an access.
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_ACC = 2'd1,
      D_ACC  = 2'd2
   } state_t;

   // Value of the wait counter on the last ACC cycle before the abort.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;

   logic        if_gnt_nxt;
   logic        d_gnt_nxt;
   logic        if_done_nxt;
   logic        d_done_nxt;
   logic        err_nxt;
   logic [31:0] rdata_nxt;
   logic        mem_en_nxt;
   logic        mem_we_nxt;
   logic [31:0] mem_addr_nxt;
   logic [31:0] mem_wdata_nxt;
   logic        busy_nxt;

   // Access direction captured at grant time.
   // It drives mem_we only while the access is in flight.
   logic        lat_we;
   logic        lat_we_nxt;

   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;

   // Arbitration runs in a free IDLE cycle and on the edge that ends an access.
   logic        arb_en;
   logic        force_if;
   logic        grant_d;
   logic        grant_if;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]  starve_cnt;
   logic [3:0]  starve_nxt;

   assign force_if = if_req && (starve_cnt >= STARVE_LIM);

   // Count data grants that overtake a waiting fetch.
   // The count restarts when the fetch is served or withdrawn.
   always_comb begin
      starve_nxt = starve_cnt;
      if (!if_req) begin
         starve_nxt = 4'd0;
      end else if (arb_en && grant_if) begin
         starve_nxt = 4'd0;
      end else if (arb_en && grant_d && (starve_cnt != 4'hF)) begin
         starve_nxt = starve_cnt + 4'd1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
      end else begin
         starve_cnt <= starve_nxt;
      end
   end
`else
   logic unused_starve;

   assign unused_starve = (STARVE_MAX > 0);
   assign force_if      = 1'b0;
`endif

   assign grant_d  = d_req && !force_if;
   assign grant_if = if_req && !grant_d;

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_nxt     = state;
      if_gnt_nxt    = 1'b0;
      d_gnt_nxt     = 1'b0;
      if_done_nxt   = 1'b0;
      d_done_nxt    = 1'b0;
      err_nxt       = 1'b0;
      rdata_nxt     = rdata;
      mem_en_nxt    = mem_en;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      busy_nxt      = busy;
      lat_we_nxt    = lat_we;
      wait_nxt      = wait_cnt;
      arb_en        = 1'b0;

      case (state)
         IDLE: begin
            if (d_gnt || if_gnt) begin
               state_nxt  = d_gnt ? D_ACC : IF_ACC;
               mem_en_nxt = 1'b1;
               mem_we_nxt = lat_we;
               busy_nxt   = 1'b1;
               wait_nxt   = 8'd0;
            end else begin
               arb_en = 1'b1;
            end
         end
         IF_ACC, D_ACC: begin
            if (mem_ready) begin
               state_nxt   = IDLE;
               mem_en_nxt  = 1'b0;
               mem_we_nxt  = 1'b0;
               busy_nxt    = 1'b0;
               if_done_nxt = (state == IF_ACC);
               d_done_nxt  = (state == D_ACC);
               rdata_nxt   = lat_we ? 32'd0 : mem_rdata;
               arb_en      = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt   = IDLE;
               mem_en_nxt  = 1'b0;
               mem_we_nxt  = 1'b0;
               busy_nxt    = 1'b0;
               if_done_nxt = (state == IF_ACC);
               d_done_nxt  = (state == D_ACC);
               err_nxt     = 1'b1;
               rdata_nxt   = 32'd0;
               arb_en      = 1'b1;
            end else begin
               wait_nxt = wait_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt  = IDLE;
            mem_en_nxt = 1'b0;
            mem_we_nxt = 1'b0;
            busy_nxt   = 1'b0;
         end
      endcase

      if (arb_en) begin
         if (grant_d) begin
            d_gnt_nxt     = 1'b1;
            lat_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
         end else if (grant_if) begin
            if_gnt_nxt    = 1'b1;
            lat_we_nxt    = 1'b0;
            mem_addr_nxt  = if_addr;
            mem_wdata_nxt = 32'd0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered outputs, latched access attributes and the wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_gnt    <= 1'b0;
         d_gnt     <= 1'b0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'd0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         busy      <= 1'b0;
         lat_we    <= 1'b0;
         wait_cnt  <= 8'd0;
      end else begin
         if_gnt    <= if_gnt_nxt;
         d_gnt     <= d_gnt_nxt;
         if_done   <= if_done_nxt;
         d_done    <= d_done_nxt;
         err       <= err_nxt;
         rdata     <= rdata_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         busy      <= busy_nxt;
         lat_we    <= lat_we_nxt;
         wait_cnt  <= wait_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter.
// The DUT is built with TIMEOUT=8 and STARVE_MAX=4.
// A memory responder raises mem_ready on the mem_lat-th ACC cycle.
// While mem_stall is set it never raises mem_ready.
// Expected completions go into a scoreboard queue when requests are driven.
// The monitor compares each done pulse against the queue head.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_done;
   logic [31:0] rdata;
   logic        err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;

   typedef struct packed {
      logic        is_data;
      logic        err;
      logic [31:0] rdata;
   } done_t;

   done_t exp_q[$];
   int    checks    = 0;
   int    errors    = 0;
   int    mem_lat   = 1;
   bit    mem_stall = 1'b0;
   int    acc_cycles = 0;

   mem_port_arbiter #(
      .STARVE_MAX(4),
      .TIMEOUT   (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_done  (if_done),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_done   (d_done),
      .rdata    (rdata),
      .err      (err),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .busy     (busy)
   );

   // Memory contents seen by the responder.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h0000_0013;
      return {a[15:0], 16'hC0DE};
   endfunction

   function automatic done_t mk(input logic d, input logic e, input logic [31:0] r);
      done_t t;
      t.is_data = d;
      t.err     = e;
      t.rdata   = r;
      return t;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: raise ready on the mem_lat-th cycle of mem_en.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      forever begin
         @(negedge clk);
         if (mem_en === 1'b1) begin
            acc_cycles++;
            if (!mem_stall && acc_cycles >= mem_lat) begin
               mem_ready = 1'b1;
               mem_rdata = mem_model(mem_addr);
            end else begin
               mem_ready = 1'b0;
               mem_rdata = 32'hBAD0_BAD0;
            end
         end else begin
            acc_cycles = 0;
            mem_ready  = 1'b0;
            mem_rdata  = 32'hBAD0_BAD0;
         end
      end
   end

   // Scoreboard monitor: compare each done pulse with the oldest expectation.
   initial begin
      done_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && (if_done === 1'b1 || d_done === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_done: got d_done=%0b if_done=%0b required no done", d_done, if_done);
            end else begin
               e = exp_q.pop_front();
               if ({d_done, if_done, err, rdata, busy} !== {e.is_data, ~e.is_data, e.err, e.rdata, 1'b0}) begin
                  errors++;
                  $display("[TB] FAIL scoreboard_done: got d=%0b i=%0b err=%0b rdata=%h busy=%0b required d=%0b err=%0b rdata=%h busy=0",
                           d_done, if_done, err, rdata, busy, e.is_data, e.err, e.rdata);
               end
            end
         end
      end
   end

   task automatic test_reset();
      tick(1);
      reset = 1'b0;
      tick(3);
      checks++;
      if ({if_gnt, if_done, d_gnt, d_done, err, mem_en, mem_we, busy} !== 8'h00 ||
          rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got ctl=%b rdata=%h addr=%h wdata=%h required all zero",
                  {if_gnt, if_done, d_gnt, d_done, err, mem_en, mem_we, busy}, rdata, mem_addr, mem_wdata);
      end
      reset = 1'b1;
      tick(2);
      checks++;
      if ({busy, if_gnt, d_gnt} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got busy/if_gnt/d_gnt=%b required 000", {busy, if_gnt, d_gnt});
      end
   endtask

   task automatic test_fetch();
      int  n;
      int  en_cnt;
      bit  hold_ok;
      mem_lat = 2;
      if_addr = 32'h0000_0040;
      if_req  = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0013));
      n = 0;
      while (if_gnt !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if (if_gnt !== 1'b1 || n != 1) begin
         errors++;
         $display("[TB] FAIL fetch_gnt: got if_gnt=%b after %0d cycles required 1 after 1", if_gnt, n);
      end
      checks++;
      if ({busy, mem_en} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL fetch_grant_cycle: got busy/mem_en=%b required 00", {busy, mem_en});
      end
      if_req  = 1'b0;
      if_addr = 32'hFFFF_0000;
      en_cnt  = 0;
      hold_ok = 1'b1;
      n = 0;
      while (if_done !== 1'b1 && n < 20) begin
         tick(1);
         n++;
         if (mem_en === 1'b1) begin
            en_cnt++;
            if (mem_addr !== 32'h0000_0040 || mem_we !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
         end
      end
      checks++;
      if (if_done !== 1'b1 || en_cnt != 2) begin
         errors++;
         $display("[TB] FAIL fetch_mem_en_cycles: got %0d (if_done=%b) required 2", en_cnt, if_done);
      end
      checks++;
      if (!hold_ok) begin
         errors++;
         $display("[TB] FAIL fetch_mem_hold: got addr/we/busy unstable required addr=00000040 we=0 busy=1");
      end
   endtask

   task automatic test_store();
      int n;
      int en_cnt;
      bit hold_ok;
      mem_lat = 3;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0200;
      d_wdata = 32'hDEAD_BEEF;
      d_req   = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 32'd0));
      n = 0;
      while (d_gnt !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if (d_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL store_gnt: got d_gnt=%b required 1", d_gnt);
      end
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 32'h0BAD_0BAD;
      d_wdata = 32'h1234_5678;
      en_cnt  = 0;
      hold_ok = 1'b1;
      n = 0;
      while (d_done !== 1'b1 && n < 20) begin
         tick(1);
         n++;
         if (mem_en === 1'b1) begin
            en_cnt++;
            if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h0000_0200) hold_ok = 1'b0;
         end
      end
      checks++;
      if (d_done !== 1'b1 || en_cnt != 3 || !hold_ok) begin
         errors++;
         $display("[TB] FAIL store_access: got cycles=%0d hold_ok=%0b d_done=%b required 3/1/1", en_cnt, hold_ok, d_done);
      end
      checks++;
      if (mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL store_we_drop: got mem_we=%b required 0", mem_we);
      end
   endtask

   task automatic test_collision();
      int n;
      mem_lat = 1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0100;
      if_addr = 32'h0000_0080;
      d_req   = 1'b1;
      if_req  = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, mem_model(32'h0000_0100)));
      exp_q.push_back(mk(1'b0, 1'b0, mem_model(32'h0000_0080)));
      n = 0;
      while (d_gnt !== 1'b1 && if_gnt !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if ({d_gnt, if_gnt} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL collision_first_gnt: got d_gnt/if_gnt=%b required 10", {d_gnt, if_gnt});
      end
      d_req = 1'b0;
      n = 0;
      while (d_done !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if ({d_done, if_gnt} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL collision_if_gnt_at_done: got d_done/if_gnt=%b required 11", {d_done, if_gnt});
      end
      if_req = 1'b0;
      n = 0;
      while (if_done !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if (if_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL collision_if_done: got if_done=%b required 1", if_done);
      end
   endtask

   task automatic test_timeout();
      int n;
      int en_cnt;
      mem_stall = 1'b1;
      if_addr   = 32'h0000_0300;
      if_req    = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b1, 32'd0));
      n = 0;
      while (if_gnt !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if (if_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_gnt: got if_gnt=%b required 1", if_gnt);
      end
      if_req = 1'b0;
      en_cnt = 0;
      n = 0;
      while (if_done !== 1'b1 && n < 40) begin
         tick(1);
         n++;
         if (mem_en === 1'b1) en_cnt++;
      end
      checks++;
      if (if_done !== 1'b1 || en_cnt != 8) begin
         errors++;
         $display("[TB] FAIL timeout_cycles: got %0d ACC cycles (if_done=%b) required 8", en_cnt, if_done);
      end
      mem_stall = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      mem_lat = 50;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0400;
      if_addr = 32'h0000_0044;
      d_req   = 1'b1;
      if_req  = 1'b1;
      n = 0;
      while (d_gnt !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if ({d_gnt, if_gnt} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL reset_mid_gnt: got d_gnt/if_gnt=%b required 10", {d_gnt, if_gnt});
      end
      d_req = 1'b0;
      n = 0;
      while (mem_en !== 1'b1 && n < 20) begin tick(1); n++; end
      tick(1);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({mem_en, busy, if_gnt, d_gnt, if_done, d_done, err} !== 7'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_async: got %b required 0000000", {mem_en, busy, if_gnt, d_gnt, if_done, d_done, err});
      end
      tick(2);
      checks++;
      if ({if_gnt, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_held_no_gnt: got if_gnt/busy=%b required 00", {if_gnt, busy});
      end
      mem_lat = 1;
      exp_q.push_back(mk(1'b0, 1'b0, mem_model(32'h0000_0044)));
      reset = 1'b1;
      tick(1);
      checks++;
      if (if_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_gnt: got if_gnt=%b required 1", if_gnt);
      end
      if_req = 1'b0;
      n = 0;
      while (if_done !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if (if_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_done: got if_done=%b required 1", if_done);
      end
   endtask

   task automatic test_back_to_back();
      int         n;
      logic [1:0] want [5];
      mem_lat = 1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0500;
      if_addr = 32'h0000_0600;
      for (int g = 0; g < 5; g++) begin
`ifdef ARB_STARVE_GUARD_EN
         want[g] = (g == 4) ? 2'b01 : 2'b10;
`else
         want[g] = 2'b10;
`endif
         if (want[g] == 2'b10) exp_q.push_back(mk(1'b1, 1'b0, mem_model(32'h0000_0500)));
         else                  exp_q.push_back(mk(1'b0, 1'b0, mem_model(32'h0000_0600)));
      end
      d_req  = 1'b1;
      if_req = 1'b1;
      for (int g = 0; g < 5; g++) begin
         n = 0;
         while (d_gnt !== 1'b1 && if_gnt !== 1'b1 && n < 20) begin tick(1); n++; end
         checks++;
         if ({d_gnt, if_gnt} !== want[g]) begin
            errors++;
            $display("[TB] FAIL grant_order_%0d: got d_gnt/if_gnt=%b required %b", g, {d_gnt, if_gnt}, want[g]);
         end
         if (g > 0) begin
            checks++;
            if ((d_done | if_done) !== 1'b1) begin
               errors++;
               $display("[TB] FAIL back_to_back_%0d: got done=%b with grant required 1", g, d_done | if_done);
            end
         end
         if (g == 4) begin
            d_req  = 1'b0;
            if_req = 1'b0;
         end
         tick(1);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin tick(1); n++; end
   endtask

   initial begin
      reset   = 1'b1;
      if_req  = 1'b0;
      if_addr = 32'd0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 32'd0;
      d_wdata = 32'd0;
      test_reset();
      test_fetch();
      test_store();
      test_collision();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      tick(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending completions required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while fetch is pending (guard build only), range 1..15.
REQ-002 SHALL have parameter TIMEOUT, default 255: ACC-state cycles without mem_ready before abort, range 1..255.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-004 Ports SHALL be, in order:
 clk  in  1  clock, rising edge
 reset  in  1  async active-low reset
 if_req  in  1  fetch request, level, held until if_gnt
 if_addr  in  32  fetch address
 if_gnt  out  1  fetch accepted, 1-cycle pulse
 if_done  out  1  fetch data valid, 1-cycle pulse
 d_req  in  1  data request, level, held until d_gnt
 d_we  in  1  1 = store, 0 = load
 d_addr  in  32  data address
 d_wdata  in  32  store data
 d_gnt  out  1  data accepted, 1-cycle pulse
 d_done  out  1  data access complete, 1-cycle pulse
 rdata  out  32  read data, valid with if_done/d_done
 err  out  1  timeout abort, 1-cycle pulse with done
 mem_en  out  1  memory access active
 mem_we  out  1  memory write enable
 mem_addr  out  32  memory address
 mem_wdata  out  32  memory write data
 mem_rdata  in  32  memory read data
 mem_ready  in  1  memory completes the access this cycle
 busy  out  1  high in any non-IDLE state

Function
REQ-005 FSM states SHALL be IDLE, IF_ACC, D_ACC; all outputs registered.
REQ-006 In IDLE with d_req=1, SHALL pulse d_gnt, latch d_addr/d_wdata/d_we, and enter D_ACC next cycle.
REQ-007 In IDLE with d_req=0 and if_req=1, SHALL pulse if_gnt, latch if_addr (we=0), and enter IF_ACC next cycle.
REQ-008 Simultaneous d_req and if_req SHALL grant data (strict priority), except as modified by REQ-019.
REQ-009 In IF_ACC/D_ACC, SHALL hold mem_en=1 and mem_addr/mem_we/mem_wdata stable at latched values; mem_we=0 in IF_ACC.
REQ-010 When mem_ready=1 in ACC, SHALL register mem_rdata into rdata, drop mem_en, and return to IDLE; next cycle SHALL pulse if_done or d_done matching the access.
REQ-011 The done pulse cycle is an IDLE cycle; a new grant MAY issue in the same cycle; minimum access = grant cycle + 1 ACC cycle + done cycle.
REQ-012 rdata SHALL hold its value until the next done; on store completion rdata SHALL be 0.
REQ-013 A wait counter SHALL clear on ACC entry and increment each ACC cycle with mem_ready=0; at TIMEOUT cycles SHALL abort to IDLE, pulse done with err=1 and rdata=0.
REQ-014 mem_ready in IDLE SHALL be ignored.
REQ-015 Requests dropped before grant SHALL not be served; request changes after grant SHALL not affect the access in flight.
REQ-016 busy SHALL be 1 in IF_ACC/D_ACC, 0 in IDLE.

Reset
REQ-017 reset=0 SHALL immediately force IDLE and drive all outputs to 0, including mem_en mid-access; counters cleared.
REQ-018 After reset release, first grant SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-019 Macro ARB_STARVE_GUARD_EN defined: a counter SHALL count data grants issued while if_req=1, clear on any fetch grant or if_req=0; at count=STARVE_MAX the next arbitration SHALL grant fetch even if d_req=1.
REQ-020 Macro undefined: strict data priority; counter logic absent; STARVE_MAX unused.

Verification
REQ-021 Fetch only: if_req=1, addr 0x0000_0040, mem_ready 2 cycles after mem_en, mem_rdata 0x0000_0013 -> if_gnt, mem_en 2 cycles, if_done with rdata 0x0000_0013.
REQ-022 Collision: if_req=1 and d_req=1 (load, addr 0x100) same cycle -> d_gnt first, d_done, then if_gnt the cycle of d_done.
REQ-023 Store: d_we=1, addr 0x200, wdata 0xDEAD_BEEF -> mem_we=1, mem_wdata 0xDEAD_BEEF while mem_en; d_done with rdata 0.
REQ-024 Timeout: TIMEOUT=8, mem_ready held 0 -> 8 ACC cycles, then done+err pulse, rdata 0, busy 0.
REQ-025 Reset mid-access: reset=0 on 2nd ACC cycle -> mem_en, busy, gnt/done fall asynchronously; after release, pending if_req granted.
REQ-026 Guard build, STARVE_MAX=4: d_req and if_req held 1 -> 4 data grants then 1 fetch grant; non-guard build -> no fetch grant while d_req=1.
